// File: rtl/uart_encoder.sv
// Transmit framer for the blackjack board link: snapshots the game state on a send
// request and writes a status byte plus three card bytes into the UART TX FIFO.
module uart_encoder #(
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       send,
  input  logic       deal,
  input  logic       dealer_finished,
  input  logic [3:0] first_card,
  input  logic [3:0] second_card,
  input  logic [3:0] third_card,
  input  logic       tx_full,
  output logic       wr_uart,
  output logic [7:0] w_data,
  output logic       busy,
  output logic       done
);

  localparam int unsigned GapW = 8;
  localparam logic [GapW-1:0] GapLoad = GapW'(GAP_CYCLES);

  typedef enum logic [2:0] {
    IDLE,
    STATUS,
    CARD1,
    CARD2,
    CARD3,
    GAP,
    FINISH
  } state_t;

  state_t            state_q, state_d;
  state_t            ret_q, ret_d;
  logic [GapW-1:0]   gap_q, gap_d;
  logic              pend_q, pend_d;
  logic              deal_q, deal_d;
  logic              fin_q, fin_d;
  logic [2:0][3:0]   cards_q, cards_d;
  logic              wr_q, wr_d;
  logic [7:0]        data_q, data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [7:0]        byte_c;
  state_t            after_c;

  // Byte to send in the current byte state and where to resume after its gap.
  always_comb begin
    byte_c  = 8'h00;
    after_c = IDLE;
    case (state_q)
      STATUS: begin
        byte_c  = {2'b00, deal_q, fin_q, 4'h0};
        after_c = CARD1;
      end
      CARD1: begin
        byte_c  = {cards_q[0], 4'h1};
        after_c = CARD2;
      end
      CARD2: begin
        byte_c  = {cards_q[1], 4'h2};
        after_c = CARD3;
      end
      CARD3: begin
        byte_c  = {cards_q[2], 4'h3};
        after_c = FINISH;
      end
      default: begin
        byte_c  = 8'h00;
        after_c = IDLE;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    gap_d   = gap_q;
    pend_d  = pend_q;
    deal_d  = deal_q;
    fin_d   = fin_q;
    cards_d = cards_q;
    wr_d    = 1'b0;
    data_d  = data_q;

    case (state_q)
      IDLE: begin
        if (send) begin
          deal_d  = deal;
          fin_d   = dealer_finished;
          cards_d = {third_card, second_card, first_card};
          state_d = STATUS;
        end
      end
      STATUS, CARD1, CARD2, CARD3: begin
        pend_d = pend_q | send;
        if (!tx_full) begin
          wr_d    = 1'b1;
          data_d  = byte_c;
          gap_d   = GapLoad;
          ret_d   = after_c;
          state_d = GAP;
        end
      end
      GAP: begin
        pend_d = pend_q | send;
        if (gap_q == '0) begin
          state_d = ret_q;
        end else begin
          gap_d = gap_q - GapW'(1);
        end
      end
      FINISH: begin
        // A request seen during the frame (or on this edge) chains straight into the next one.
        if (pend_q || send) begin
          pend_d  = 1'b0;
          deal_d  = deal;
          fin_d   = dealer_finished;
          cards_d = {third_card, second_card, first_card};
          state_d = STATUS;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == FINISH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ret_q   <= IDLE;
      gap_q   <= '0;
      pend_q  <= 1'b0;
      deal_q  <= 1'b0;
      fin_q   <= 1'b0;
      cards_q <= '0;
      wr_q    <= 1'b0;
      data_q  <= 8'h00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      gap_q   <= gap_d;
      pend_q  <= pend_d;
      deal_q  <= deal_d;
      fin_q   <= fin_d;
      cards_q <= cards_d;
      wr_q    <= wr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign wr_uart = wr_q;
  assign w_data  = data_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_uart_encoder.sv
// Bench for uart_encoder: two instances (gap 0 and gap 3) share stimulus and are
// compared cycle by cycle against a frame-level reference model.
module tb_uart_encoder;

  localparam int N    = 300;
  localparam int NMAX = 360;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       send = 1'b0;
  logic       deal = 1'b0;
  logic       df = 1'b0;
  logic [3:0] c1 = 4'h0;
  logic [3:0] c2 = 4'h0;
  logic [3:0] c3 = 4'h0;
  logic       tx_full = 1'b0;

  logic       wr_o   [2];
  logic [7:0] wd_o   [2];
  logic       busy_o [2];
  logic       done_o [2];

  logic       send_at [NMAX];
  logic       full_at [NMAX];
  logic       deal_at [NMAX];
  logic       df_at   [NMAX];
  logic [3:0] c1_at   [NMAX];
  logic [3:0] c2_at   [NMAX];
  logic [3:0] c3_at   [NMAX];

  logic       exp_wr   [2][NMAX];
  logic [7:0] exp_wd   [2][NMAX];
  logic       exp_busy [2][NMAX];
  logic       exp_done [2][NMAX];

  logic       obs_wr   [2][NMAX];
  logic [7:0] obs_wd   [2][NMAX];
  logic       obs_busy [2][NMAX];
  logic       obs_done [2][NMAX];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_encoder #(.GAP_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .send(send), .deal(deal), .dealer_finished(df),
    .first_card(c1), .second_card(c2), .third_card(c3), .tx_full(tx_full),
    .wr_uart(wr_o[0]), .w_data(wd_o[0]), .busy(busy_o[0]), .done(done_o[0])
  );

  uart_encoder #(.GAP_CYCLES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .send(send), .deal(deal), .dealer_finished(df),
    .first_card(c1), .second_card(c2), .third_card(c3), .tx_full(tx_full),
    .wr_uart(wr_o[1]), .w_data(wd_o[1]), .busy(busy_o[1]), .done(done_o[1])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_stim();
    for (int k = 0; k < NMAX; k++) begin
      send_at[k] = 1'b0;
      full_at[k] = 1'b0;
      deal_at[k] = 1'b0;
      df_at[k]   = 1'b0;
      c1_at[k]   = 4'h0;
      c2_at[k]   = 4'h0;
      c3_at[k]   = 4'h0;
    end
  endtask

  task automatic set_const(input logic dl, input logic fn, input logic [3:0] a,
                           input logic [3:0] b, input logic [3:0] c);
    for (int k = 0; k < NMAX; k++) begin
      deal_at[k] = dl;
      df_at[k]   = fn;
      c1_at[k]   = a;
      c2_at[k]   = b;
      c3_at[k]   = c;
    end
  endtask

  // Frame-level model: each frame snapshots at its start edge, each byte goes out on the
  // first edge the FIFO reads not-full, bytes are spaced 2+g, done follows 1+g later.
  task automatic build_model(input int di, input int g);
    int s, e, d, nxt;
    int w [4];
    logic [7:0] b [4];
    logic [7:0] last;
    for (int k = 0; k < NMAX; k++) begin
      exp_wr[di][k]   = 1'b0;
      exp_wd[di][k]   = 8'h00;
      exp_busy[di][k] = 1'b0;
      exp_done[di][k] = 1'b0;
    end
    s = -1;
    for (int k = 0; k < N; k++) if (send_at[k] && s < 0) s = k;
    while (s >= 0 && s < N) begin
      b[0] = {2'b00, deal_at[s], df_at[s], 4'h0};
      b[1] = {c1_at[s], 4'h1};
      b[2] = {c2_at[s], 4'h2};
      b[3] = {c3_at[s], 4'h3};
      e = s + 1;
      for (int i = 0; i < 4; i++) begin
        while (full_at[e]) e++;
        exp_wr[di][e] = 1'b1;
        exp_wd[di][e] = b[i];
        w[i] = e;
        e = e + 2 + g;
      end
      d = w[3] + 1 + g;
      for (int k = s; k <= d; k++) exp_busy[di][k] = 1'b1;
      exp_done[di][d] = 1'b1;
      nxt = -1;
      for (int k = s + 1; k <= d + 1; k++) if (send_at[k]) nxt = d + 1;
      if (nxt < 0)
        for (int k = d + 2; k < N; k++) if (send_at[k] && nxt < 0) nxt = k;
      s = nxt;
    end
    last = 8'h00;
    for (int k = 0; k < NMAX; k++) begin
      if (exp_wr[di][k]) last = exp_wd[di][k];
      exp_wd[di][k] = last;
    end
  endtask

  task automatic check_zero(input string tag);
    for (int di = 0; di < 2; di++) begin
      check_eq($sformatf("%s_d%0d_wr", tag, di), 32'(wr_o[di]), 32'd0);
      check_eq($sformatf("%s_d%0d_wd", tag, di), 32'(wd_o[di]), 32'd0);
      check_eq($sformatf("%s_d%0d_busy", tag, di), 32'(busy_o[di]), 32'd0);
      check_eq($sformatf("%s_d%0d_done", tag, di), 32'(done_o[di]), 32'd0);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    send    = 1'b0;
    tx_full = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_zero("rst");
    rst_n = 1'b1;
  endtask

  task automatic run_scenario(input bit do_reset);
    if (do_reset) apply_reset();
    build_model(0, 0);
    build_model(1, 3);
    for (int k = 0; k < N; k++) begin
      send    = send_at[k];
      tx_full = full_at[k];
      deal    = deal_at[k];
      df      = df_at[k];
      c1      = c1_at[k];
      c2      = c2_at[k];
      c3      = c3_at[k];
      @(posedge clk);
      @(negedge clk);
      for (int di = 0; di < 2; di++) begin
        obs_wr[di][k]   = wr_o[di];
        obs_wd[di][k]   = wd_o[di];
        obs_busy[di][k] = busy_o[di];
        obs_done[di][k] = done_o[di];
        check_eq($sformatf("d%0d_wr_c%0d", di, k), 32'(wr_o[di]), 32'(exp_wr[di][k]));
        check_eq($sformatf("d%0d_wd_c%0d", di, k), 32'(wd_o[di]), 32'(exp_wd[di][k]));
        check_eq($sformatf("d%0d_busy_c%0d", di, k), 32'(busy_o[di]), 32'(exp_busy[di][k]));
        check_eq($sformatf("d%0d_done_c%0d", di, k), 32'(done_o[di]), 32'(exp_done[di][k]));
      end
    end
    send    = 1'b0;
    tx_full = 1'b0;
  endtask

  task automatic gen_random(input int sc);
    logic [3:0] a, b, c;
    logic dl, fn;
    int k, len;
    clear_stim();
    a  = 4'($urandom);
    b  = 4'($urandom);
    c  = 4'($urandom);
    dl = 1'($urandom);
    fn = 1'($urandom);
    for (int i = 0; i < N; i++) begin
      if ($urandom_range(0, 7) == 0) a = 4'($urandom);
      if ($urandom_range(0, 7) == 0) b = 4'($urandom);
      if ($urandom_range(0, 7) == 0) c = 4'($urandom);
      if ($urandom_range(0, 7) == 0) dl = ~dl;
      if ($urandom_range(0, 7) == 0) fn = ~fn;
      deal_at[i] = dl;
      df_at[i]   = fn;
      c1_at[i]   = a;
      c2_at[i]   = b;
      c3_at[i]   = c;
      send_at[i] = (i < 120) && ($urandom_range(0, 11) == 0);
      if (sc == 0 && i < 40) send_at[i] = 1'b1;
    end
    k = 0;
    while (k < 150) begin
      if ($urandom_range(0, 14) == 0) begin
        len = int'($urandom_range(1, 9));
        for (int j = 0; j < len; j++) if (k + j < 150) full_at[k + j] = 1'b1;
        k = k + len;
      end else begin
        k++;
      end
    end
  endtask

  function automatic int count_wr(input int di, input int lo, input int hi);
    int cnt = 0;
    for (int k = lo; k <= hi; k++) if (obs_wr[di][k]) cnt++;
    return cnt;
  endfunction

  initial begin
    // Basic frame
    clear_stim();
    set_const(1'b1, 1'b0, 4'hA, 4'h3, 4'h7);
    send_at[0] = 1'b1;
    run_scenario(1'b1);
    check_eq("basic_status", 32'({obs_wr[0][1], obs_wd[0][1]}), 32'h120);
    check_eq("basic_card1",  32'({obs_wr[0][3], obs_wd[0][3]}), 32'h1A1);
    check_eq("basic_card2",  32'({obs_wr[0][5], obs_wd[0][5]}), 32'h132);
    check_eq("basic_card3",  32'({obs_wr[0][7], obs_wd[0][7]}), 32'h173);
    check_eq("basic_done",   32'(obs_done[0][8]), 32'd1);
    check_eq("basic_nwr",    32'(count_wr(0, 0, N - 1)), 32'd4);
    check_eq("basic_idle9",  32'(obs_busy[0][9]), 32'd0);
    check_eq("gap3_card1",   32'({obs_wr[1][6], obs_wd[1][6]}), 32'h1A1);
    check_eq("gap3_done",    32'(obs_done[1][20]), 32'd1);

    // Back-pressure across the card2 write
    clear_stim();
    set_const(1'b1, 1'b0, 4'hA, 4'h3, 4'h7);
    send_at[0] = 1'b1;
    for (int k = 4; k < 14; k++) full_at[k] = 1'b1;
    run_scenario(1'b1);
    check_eq("bp_nowr_full", 32'(count_wr(0, 4, 13)), 32'd0);
    check_eq("bp_card2",     32'({obs_wr[0][14], obs_wd[0][14]}), 32'h132);
    check_eq("bp_card3",     32'({obs_wr[0][16], obs_wd[0][16]}), 32'h173);

    // Snapshot and pending merge
    clear_stim();
    set_const(1'b0, 1'b1, 4'hA, 4'h3, 4'h7);
    for (int k = 2; k < NMAX; k++) c1_at[k] = 4'h5;
    send_at[0] = 1'b1;
    send_at[2] = 1'b1;
    send_at[4] = 1'b1;
    run_scenario(1'b1);
    check_eq("pend_old_card", 32'({obs_wr[0][3], obs_wd[0][3]}), 32'h1A1);
    check_eq("pend_no_idle",  32'(obs_busy[0][9]), 32'd1);
    check_eq("pend_new_card", 32'({obs_wr[0][12], obs_wd[0][12]}), 32'h151);
    check_eq("pend_two_frm",  32'(count_wr(0, 0, N - 1)), 32'd8);

    // Randomized scenarios
    for (int sc = 0; sc < 8; sc++) begin
      gen_random(sc);
      run_scenario(1'b1);
    end

    // Asynchronous reset between card1 and card2
    apply_reset();
    deal = 1'b1;
    df   = 1'b0;
    c1   = 4'hA;
    c2   = 4'h3;
    c3   = 4'h7;
    send = 1'b1;
    @(posedge clk);
    @(negedge clk);
    send = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    clear_stim();
    set_const(1'b0, 1'b0, 4'h9, 4'h2, 4'hE);
    send_at[25] = 1'b1;
    run_scenario(1'b0);
    check_eq("rst_quiet", 32'(count_wr(0, 0, 25)), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
